// File: rtl/moore_step_seq_pkg.sv
// Shared command encodings and helper functions for the moore_step_seq stepper.
package moore_step_seq_pkg;

    localparam int unsigned CMD_W  = 2;
    localparam int unsigned GRAY_W = 8;

    typedef enum logic [CMD_W-1:0] {
        CMD_HOLD = 2'b00,
        CMD_BACK = 2'b01,
        CMD_FWD  = 2'b10
    } cmd_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res++;
        end
        return res;
    endfunction

    // Both or neither command asserted collapses to HOLD.
    function automatic cmd_e cmd_decode(input logic fwd, input logic back);
        case ({fwd, back})
            2'b10:   return CMD_FWD;
            2'b01:   return CMD_BACK;
            default: return CMD_HOLD;
        endcase
    endfunction

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/moore_step_seq_if.sv
// Command inputs and encoded state outputs of the moore_step_seq stepper.
interface moore_step_seq_if #(
    parameter int unsigned OUT_W = 2
);
    logic             inA;
    logic             inB;
    logic [OUT_W-1:0] out_state;
    logic             at_first;
    logic             at_last;
    logic             step_pulse;

    modport master (
        output inA, inB,
        input  out_state, at_first, at_last, step_pulse
    );

    modport slave (
        input  inA, inB,
        output out_state, at_first, at_last, step_pulse
    );
endinterface

// File: rtl/moore_step_seq_dwell.sv
// Command dwell qualifier: turns held commands into one-cycle step strobes.
// MOORE_SEQ_EDGE_EN: one step per command press instead of auto-repeat.
module moore_step_seq_dwell
    import moore_step_seq_pkg::*;
#(
    parameter int unsigned DWELL = 1
) (
    input  logic clk,
    input  logic reset,
    input  cmd_e cmd,
    output logic step_fwd_c,
    output logic step_back_c
);

    localparam int unsigned      RUN_W    = clog2(DWELL + 1);
    localparam logic [RUN_W-1:0] RUN_DONE = RUN_W'(DWELL);

    cmd_e             last_cmd_q, last_cmd_d;
    logic [RUN_W-1:0] run_q, run_d, run_upd;
    logic             locked, step;
`ifdef MOORE_SEQ_EDGE_EN
    logic             lock_q, lock_d;
`endif

    // Run length of the current command; a step consumes the run.
    always_comb begin
        last_cmd_d = cmd;
        run_upd    = '0;
        locked     = 1'b0;
`ifdef MOORE_SEQ_EDGE_EN
        lock_d     = 1'b0;
        locked     = lock_q && (cmd == last_cmd_q);
`endif
        if (cmd == CMD_HOLD) begin
            run_upd = '0;
        end else if (cmd == last_cmd_q) begin
            run_upd = run_q + RUN_W'(1);
        end else begin
            run_upd = RUN_W'(1);
        end
        step  = (cmd != CMD_HOLD) && !locked && (run_upd == RUN_DONE);
        run_d = (step || locked) ? '0 : run_upd;
`ifdef MOORE_SEQ_EDGE_EN
        lock_d = step || locked;
`endif
        step_fwd_c  = step && (cmd == CMD_FWD);
        step_back_c = step && (cmd == CMD_BACK);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_cmd_q <= CMD_HOLD;
            run_q      <= '0;
`ifdef MOORE_SEQ_EDGE_EN
            lock_q     <= 1'b0;
`endif
        end else begin
            last_cmd_q <= last_cmd_d;
            run_q      <= run_d;
`ifdef MOORE_SEQ_EDGE_EN
            lock_q     <= lock_d;
`endif
        end
    end

endmodule

// File: rtl/moore_step_seq.sv
// N-state Moore sequencer: inA steps forward, inB steps back after a dwell.
// MOORE_SEQ_EDGE_EN (in the dwell sub-module) selects one step per press.
module moore_step_seq
    import moore_step_seq_pkg::*;
#(
    parameter int unsigned N_STATES = 4,
    parameter int unsigned OUT_W    = 2,
    parameter int unsigned DWELL    = 1,
    parameter int unsigned WRAP     = 1,
    parameter int unsigned GRAY     = 0
) (
    input  logic              clk,
    input  logic              reset,
    moore_step_seq_if.slave   bus
);

    localparam int unsigned      IDX_W    = clog2(N_STATES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_STATES - 1);

    cmd_e             cmd;
    logic             step_fwd_c, step_back_c;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [OUT_W-1:0] out_state_q, out_state_d;
    logic             at_first_q, at_first_d;
    logic             at_last_q, at_last_d;
    logic             step_pulse_q, step_pulse_d;

    assign cmd = cmd_decode(bus.inA, bus.inB);

    moore_step_seq_dwell #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk         (clk),
        .reset       (reset),
        .cmd         (cmd),
        .step_fwd_c  (step_fwd_c),
        .step_back_c (step_back_c)
    );

    // Wrap/saturate next state; outputs are encoded from idx_d so they land with idx_q.
    always_comb begin
        idx_d = idx_q;
        if (32'(idx_q) >= N_STATES) begin
            idx_d = '0;
        end else if (step_fwd_c) begin
            if (idx_q != IDX_LAST) begin
                idx_d = idx_q + IDX_W'(1);
            end else if (WRAP != 0) begin
                idx_d = '0;
            end
        end else if (step_back_c) begin
            if (idx_q != '0) begin
                idx_d = idx_q - IDX_W'(1);
            end else if (WRAP != 0) begin
                idx_d = IDX_LAST;
            end
        end
        // Recovery from an illegal code is not a step.
        step_pulse_d = (32'(idx_q) < N_STATES) && (idx_d != idx_q);
        out_state_d  = (GRAY != 0) ? OUT_W'(bin2gray(GRAY_W'(idx_d))) : OUT_W'(idx_d);
        at_first_d   = (idx_d == '0);
        at_last_d    = (idx_d == IDX_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q        <= '0;
            out_state_q  <= '0;
            at_first_q   <= 1'b1;
            at_last_q    <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            out_state_q  <= out_state_d;
            at_first_q   <= at_first_d;
            at_last_q    <= at_last_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign bus.out_state  = out_state_q;
    assign bus.at_first   = at_first_q;
    assign bus.at_last    = at_last_q;
    assign bus.step_pulse = step_pulse_q;

endmodule

// File: tb/tb_moore_step_seq.sv
// Scoreboard bench for moore_step_seq: four configurations, expected outputs queued per edge.
`timescale 1ns/1ps
module tb_moore_step_seq;

    typedef struct packed {
        logic [2:0] st;
        logic       first;
        logic       last;
        logic       pulse;
    } obs_t;

    typedef struct {
        logic a;
        logic b;
        logic rst;
        int   n;
    } seg_t;

    localparam int NUM = 4;
    localparam int N_P [NUM] = '{4, 5, 4, 5};
    localparam int D_P [NUM] = '{1, 1, 3, 2};
    localparam int W_P [NUM] = '{1, 0, 1, 1};
    localparam int G_P [NUM] = '{0, 0, 0, 1};
`ifdef MOORE_SEQ_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    moore_step_seq_if #(.OUT_W(2)) if_a ();
    moore_step_seq_if #(.OUT_W(3)) if_b ();
    moore_step_seq_if #(.OUT_W(2)) if_c ();
    moore_step_seq_if #(.OUT_W(3)) if_d ();

    moore_step_seq #(.N_STATES(N_P[0]), .OUT_W(2), .DWELL(D_P[0]), .WRAP(W_P[0]), .GRAY(G_P[0]))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    moore_step_seq #(.N_STATES(N_P[1]), .OUT_W(3), .DWELL(D_P[1]), .WRAP(W_P[1]), .GRAY(G_P[1]))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));
    moore_step_seq #(.N_STATES(N_P[2]), .OUT_W(2), .DWELL(D_P[2]), .WRAP(W_P[2]), .GRAY(G_P[2]))
        dut_c (.clk(clk), .reset(reset), .bus(if_c));
    moore_step_seq #(.N_STATES(N_P[3]), .OUT_W(3), .DWELL(D_P[3]), .WRAP(W_P[3]), .GRAY(G_P[3]))
        dut_d (.clk(clk), .reset(reset), .bus(if_d));

    // Reference model state per instance
    int   m_idx   [NUM];
    int   m_run   [NUM];
    int   m_last  [NUM];
    bit   m_lock  [NUM];
    bit   m_pulse [NUM];
    obs_t exp_q [$];
    int   checks = 0;
    int   passes = 0;

    task automatic model_edge(input int i, input logic a, input logic b, input logic rst);
        int  cmd, old, nxt;
        bit  locked, step;
        if (!rst) begin
            m_idx[i] = 0; m_run[i] = 0; m_last[i] = 0; m_lock[i] = 0; m_pulse[i] = 0;
        end else begin
            cmd    = (a && !b) ? 1 : ((b && !a) ? 2 : 0);
            locked = EDGE && m_lock[i] && (cmd == m_last[i]);
            old    = m_idx[i];
            nxt    = old;
            if (cmd == 0 || locked) m_run[i] = 0;
            else if (cmd == m_last[i]) m_run[i] = m_run[i] + 1;
            else m_run[i] = 1;
            step = (cmd != 0) && !locked && (m_run[i] == D_P[i]);
            if (step) begin
                m_run[i] = 0;
                if (cmd == 1) nxt = (old == N_P[i] - 1) ? ((W_P[i] != 0) ? 0 : old) : old + 1;
                else          nxt = (old == 0) ? ((W_P[i] != 0) ? N_P[i] - 1 : 0) : old - 1;
            end
            if (cmd != m_last[i]) m_lock[i] = 0;
            if (step && EDGE) m_lock[i] = 1;
            m_pulse[i] = (nxt != old);
            m_idx[i]   = nxt;
            m_last[i]  = cmd;
        end
    endtask

    function automatic obs_t model_out(input int i);
        obs_t e;
        int   v;
        v       = (G_P[i] != 0) ? (m_idx[i] ^ (m_idx[i] >> 1)) : m_idx[i];
        e.st    = 3'(v);
        e.first = (m_idx[i] == 0);
        e.last  = (m_idx[i] == N_P[i] - 1);
        e.pulse = m_pulse[i];
        return e;
    endfunction

    function automatic obs_t observe(input int sel);
        obs_t o;
        case (sel)
            0:       o = '{3'(if_a.out_state), if_a.at_first, if_a.at_last, if_a.step_pulse};
            1:       o = '{3'(if_b.out_state), if_b.at_first, if_b.at_last, if_b.step_pulse};
            2:       o = '{3'(if_c.out_state), if_c.at_first, if_c.at_last, if_c.step_pulse};
            default: o = '{3'(if_d.out_state), if_d.at_first, if_d.at_last, if_d.step_pulse};
        endcase
        return o;
    endfunction

    // One edge: drive commands to the selected instance, queue its expected outputs.
    task automatic drive(input int sel, input logic a, input logic b, input logic rst);
        @(negedge clk);
        reset    = rst;
        if_a.inA = (sel == 0) && a;  if_a.inB = (sel == 0) && b;
        if_b.inA = (sel == 1) && a;  if_b.inB = (sel == 1) && b;
        if_c.inA = (sel == 2) && a;  if_c.inB = (sel == 2) && b;
        if_d.inA = (sel == 3) && a;  if_d.inB = (sel == 3) && b;
        for (int i = 0; i < NUM; i++) begin
            model_edge(i, (i == sel) ? a : 1'b0, (i == sel) ? b : 1'b0, rst);
        end
        exp_q.push_back(model_out(sel));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t o, e;
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, 1'b0, 1'b0);
            o = observe(0); e = exp_q.pop_front(); checks++;
            if (o !== e) $display("FAIL reset[%0d]: got %p expected %p", k, o, e);
            else passes++;
        end
        checks++;
        if (o !== obs_t'({3'd0, 1'b1, 1'b0, 1'b0})) $display("FAIL reset_const: got %p expected st=0 first=1", o);
        else passes++;
    endtask

    task automatic test_wrap();
        seg_t segs [2];
        obs_t o, e;
        segs = '{'{1'b1, 1'b0, 1'b1, 5}, '{1'b0, 1'b1, 1'b1, 2}};
        foreach (segs[s]) for (int k = 0; k < segs[s].n; k++) begin
            drive(0, segs[s].a, segs[s].b, segs[s].rst);
            o = observe(0); e = exp_q.pop_front(); checks++;
            if (o !== e) $display("FAIL wrap[%0d.%0d]: got %p expected %p", s, k, o, e);
            else passes++;
        end
        checks++;
        if (o.st !== (EDGE ? 3'd0 : 3'd3)) $display("FAIL wrap_final: got %0d expected %0d", o.st, EDGE ? 0 : 3);
        else passes++;
    endtask

    task automatic test_saturate();
        seg_t segs [3];
        obs_t o, e;
        int   pulses = 0;
        segs = '{'{1'b0, 1'b0, 1'b0, 1}, '{1'b0, 1'b1, 1'b1, 1}, '{1'b1, 1'b0, 1'b1, 6}};
        foreach (segs[s]) for (int k = 0; k < segs[s].n; k++) begin
            drive(1, segs[s].a, segs[s].b, segs[s].rst);
            o = observe(1); e = exp_q.pop_front(); checks++;
            pulses += int'(o.pulse);
            if (o !== e) $display("FAIL saturate[%0d.%0d]: got %p expected %p", s, k, o, e);
            else passes++;
        end
        checks++;
        if (pulses !== (EDGE ? 1 : 4)) $display("FAIL saturate_pulses: got %0d expected %0d", pulses, EDGE ? 1 : 4);
        else passes++;
    endtask

    task automatic test_dwell();
        seg_t segs [7];
        obs_t o, e;
        segs = '{'{1'b0, 1'b0, 1'b0, 1}, '{1'b1, 1'b0, 1'b1, 2}, '{1'b0, 1'b0, 1'b1, 1},
                 '{1'b1, 1'b0, 1'b1, 3}, '{1'b1, 1'b0, 1'b1, 6}, '{1'b1, 1'b1, 1'b1, 2},
                 '{1'b1, 1'b0, 1'b1, 2}};
        foreach (segs[s]) for (int k = 0; k < segs[s].n; k++) begin
            drive(2, segs[s].a, segs[s].b, segs[s].rst);
            o = observe(2); e = exp_q.pop_front(); checks++;
            if (o !== e) $display("FAIL dwell[%0d.%0d]: got %p expected %p", s, k, o, e);
            else passes++;
        end
        checks++;
        if (o.st !== (EDGE ? 3'd1 : 3'd3)) $display("FAIL dwell_final: got %0d expected %0d", o.st, EDGE ? 1 : 3);
        else passes++;
    endtask

    task automatic test_reset_mid_dwell();
        seg_t segs [5];
        obs_t o, e;
        segs = '{'{1'b0, 1'b0, 1'b0, 1}, '{1'b1, 1'b0, 1'b1, 2}, '{1'b1, 1'b0, 1'b0, 1},
                 '{1'b1, 1'b0, 1'b1, 2}, '{1'b1, 1'b0, 1'b1, 1}};
        foreach (segs[s]) for (int k = 0; k < segs[s].n; k++) begin
            drive(2, segs[s].a, segs[s].b, segs[s].rst);
            o = observe(2); e = exp_q.pop_front(); checks++;
            if (o !== e) $display("FAIL mid_reset[%0d.%0d]: got %p expected %p", s, k, o, e);
            else passes++;
            if (s == 3) begin
                checks++;
                if (o.st !== 3'd0) $display("FAIL mid_reset_hold: got %0d expected 0", o.st);
                else passes++;
            end
        end
        checks++;
        if (o.st !== 3'd1 || o.pulse !== 1'b1) $display("FAIL mid_reset_step: got st=%0d p=%b expected st=1 p=1", o.st, o.pulse);
        else passes++;
    endtask

    task automatic test_gray();
        seg_t segs [3];
        obs_t o, e;
        segs = '{'{1'b0, 1'b0, 1'b0, 1}, '{1'b1, 1'b0, 1'b1, 12}, '{1'b0, 1'b1, 1'b1, 4}};
        foreach (segs[s]) for (int k = 0; k < segs[s].n; k++) begin
            drive(3, segs[s].a, segs[s].b, segs[s].rst);
            o = observe(3); e = exp_q.pop_front(); checks++;
            if (o !== e) $display("FAIL gray[%0d.%0d]: got %p expected %p", s, k, o, e);
            else passes++;
        end
        checks++;
        if (o.st !== (EDGE ? 3'd0 : 3'd6) || o.last !== !EDGE) $display("FAIL gray_final: got st=%0d l=%b", o.st, o.last);
        else passes++;
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        for (int sel = 0; sel < 3; sel += 2) begin
            drive(sel, 1'b0, 1'b0, 1'b0);
            void'(exp_q.pop_front());
            for (int k = 0; k < 6; k++) begin
                drive(sel, k[0] == 1'b0, k[0] == 1'b1, 1'b1);
                o = observe(sel); e = exp_q.pop_front(); checks++;
                if (o !== e) $display("FAIL b2b%0d[%0d]: got %p expected %p", sel, k, o, e);
                else passes++;
            end
        end
    endtask

`ifdef MOORE_SEQ_EDGE_EN
    task automatic test_edge_lock();
        seg_t segs [5];
        obs_t o, e;
        int   pulses = 0;
        segs = '{'{1'b0, 1'b0, 1'b0, 1}, '{1'b1, 1'b0, 1'b1, 10}, '{1'b0, 1'b0, 1'b1, 1},
                 '{1'b1, 1'b0, 1'b1, 1}, '{1'b0, 1'b1, 1'b1, 1}};
        foreach (segs[s]) for (int k = 0; k < segs[s].n; k++) begin
            drive(0, segs[s].a, segs[s].b, segs[s].rst);
            o = observe(0); e = exp_q.pop_front(); checks++;
            pulses += int'(o.pulse);
            if (o !== e) $display("FAIL edge_lock[%0d.%0d]: got %p expected %p", s, k, o, e);
            else passes++;
        end
        checks++;
        if (pulses !== 3 || o.st !== 3'd1) $display("FAIL edge_lock_final: got pulses=%0d st=%0d expected 3,1", pulses, o.st);
        else passes++;
    endtask
`endif

    initial begin
        reset    = 1'b0;
        if_a.inA = 1'b0; if_a.inB = 1'b0;
        if_b.inA = 1'b0; if_b.inB = 1'b0;
        if_c.inA = 1'b0; if_c.inB = 1'b0;
        if_d.inA = 1'b0; if_d.inB = 1'b0;
        test_reset();
        test_wrap();
        test_saturate();
        test_dwell();
        test_reset_mid_dwell();
        test_gray();
        test_back_to_back();
`ifdef MOORE_SEQ_EDGE_EN
        test_edge_lock();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
